popcount_stream: RTL

Sequential, parameterised population counter with valid/ready handshakes. It is the clocked successor to the combinational N-input 1-bit adder. The block accepts WIDTH-bit words, counts set bits CHUNK bits per cycle, and accumulates the count across a multi-word frame delimited by `in_last`. It sits between a bit-vector source and any consumer that needs a per-frame ones count, and trades latency for adder width.

---
 rtl/popcount_stream.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/popcount_stream.sv
// Streaming per-frame ones counter: scans each word CHUNK bits per cycle into a saturating accumulator.
// Define POPCOUNT_STREAM_THRESH_EN to add the thresh input and the registered out_above flag.
module popcount_stream #(
   parameter int WIDTH = 14,
   parameter int CHUNK = 4,
   parameter int ACC_W = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_count,
   output logic             out_ovf
`ifdef POPCOUNT_STREAM_THRESH_EN
   ,
   input  logic [ACC_W-1:0] thresh,
   output logic             out_above
`endif
);

   localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int SUM_W  = $clog2(CHUNK + 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sreg_q, sreg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               last_q, last_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               ovf_q, ovf_d;

   logic [SUM_W-1:0]   chunk_sum;
   logic [ACC_W:0]     acc_sum;
   logic               sat;
   logic [ACC_W-1:0]   acc_next;
   logic               last_chunk;

   // Zero-fill shifting guarantees the final partial chunk only sees in-range bits.
   always_comb begin
      chunk_sum = '0;
      for (int unsigned i = 0; i < CHUNK; i++) begin
         chunk_sum = chunk_sum + SUM_W'(sreg_q[i]);
      end
   end

   assign acc_sum    = {1'b0, acc_q} + (ACC_W + 1)'(chunk_sum);
   assign sat        = acc_sum[ACC_W];
   assign acc_next   = sat ? '1 : acc_sum[ACC_W-1:0];
   assign last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));

   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      acc_d     = acc_q;
      ovf_d     = ovf_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               sreg_d  = in_data;
               last_d  = in_last;
               cnt_d   = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            sreg_d = sreg_q >> CHUNK;
            cnt_d  = cnt_q + CNT_W'(1);
            acc_d  = acc_next;
            ovf_d  = ovf_q | sat;
            if (last_chunk) begin
               state_d = last_q ? DONE : IDLE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               acc_d   = '0;
               ovf_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out_count = acc_q;
   assign out_ovf   = ovf_q;

`ifdef POPCOUNT_STREAM_THRESH_EN
   logic above_q, above_d;

   // Compared against the saturated value being written on the edge that enters DONE.
   always_comb begin
      above_d = above_q;
      if (state_q == SCAN && last_chunk && last_q) begin
         above_d = (acc_next >= thresh);
      end else if (state_q == DONE && out_ready) begin
         above_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         above_q <= 1'b0;
      end else begin
         above_q <= above_d;
      end
   end

   assign out_above = above_q;
`endif

endmodule
